// File: rtl/lane_defs.sv
// Shared lane constants for the demux, mux and lane FIFOs.
// Widths, FIFO depth and almost-full/empty thresholds.
package lane_defs;

  localparam int LANE_DATA_W = 8;
  localparam int LANE_DEPTH  = 4;
  localparam int LANE_ADDR_W = $clog2(LANE_DEPTH);
  localparam int LANE_AF     = 3;
  localparam int LANE_AE     = 1;

endpackage

// File: rtl/fifo_mem.sv
// Lane FIFO storage: DEPTH x DATA_W registers.
// One write port, one registered read port.
module fifo_mem
  import lane_defs::*;
#(
  parameter int DATA_W = LANE_DATA_W,
  parameter int DEPTH  = LANE_DEPTH,
  parameter int ADDR_W = LANE_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Storage is never cleared; a same-address
  // read returns the word before this write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read register loads on rd_en, else holds.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Read register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_lane.sv
// Per-lane synchronous FIFO behind the demux.
// Pointers, count, flags, read valid, sticky overflow.
module fifo_lane
  import lane_defs::*;
#(
  parameter int DATA_W    = LANE_DATA_W,
  parameter int DEPTH     = LANE_DEPTH,
  parameter int ADDR_W    = LANE_ADDR_W,
  parameter int AF_THRESH = LANE_AF,
  parameter int AE_THRESH = LANE_AE
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              push,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              err_overflow
);

  localparam logic [ADDR_W:0] CNT_FULL =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_AF =
    (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] CNT_AE =
    (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0] CNT_ONE =
    (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE =
    ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              push_acc, pop_acc;

  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);

  // Accept logic and next-state for pointers,
  // count, read valid and the overflow flag.
  always_comb begin
    pop_acc  = pop && !empty;
    push_acc = push && (!full || pop_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    valid_d = pop_acc;
    ovf_d   = ovf_q | (push && full && !pop);
  end

  // Control state; reset wins over push/pop.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset_L (reset_L),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

  assign valid_out    = valid_q;
  assign err_overflow = ovf_q;

endmodule
